// File: rtl/text_write_ctrl_if.sv
// Text RAM write port shared by the write controller (master) and the RAM (slave).
// wr_en acts as a valid with an implied always-ready sink: the RAM takes wr_addr/wr_data on every clk where wr_en=1.
interface text_write_ctrl_if #(
  parameter int ADDR_W = 12
);
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              wr_en;

  modport master (output wr_addr, output wr_data, output wr_en);
  modport slave  (input  wr_addr, input  wr_data, input  wr_en);
endinterface

// File: rtl/text_write_ctrl.sv
// Character-stream write controller for the 80x30 text RAM with a hardware cursor.
// Optional feature macro: CURSOR_ESC_EN enables the ESC,col,row absolute cursor sequence.
module text_write_ctrl #(
  parameter int         COLS   = 80,
  parameter int         ROWS   = 30,
  parameter int         ADDR_W = 12,
  parameter logic [7:0] BLANK  = 8'h20
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [7:0]          spi_shift_reg,
  input  logic [2:0]          spi_done,
  text_write_ctrl_if.master   wr,
  output logic [6:0]          cursor_col,
  output logic [4:0]          cursor_row,
  output logic                busy,
  output logic                overflow,
  output logic [1:0]          fsm_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CLEAR   = 2'd1
`ifdef CURSOR_ESC_EN
    ,
    ESC_COL = 2'd2,
    ESC_ROW = 2'd3
`endif
  } state_t;

  localparam logic [ADDR_W-1:0] COLS_A  = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(COLS * ROWS - 1);
  localparam logic [6:0]        COL_MAX = 7'(COLS - 1);
  localparam logic [4:0]        ROW_MAX = 5'(ROWS - 1);

  state_t            state, state_d;
  logic [7:0]        hold_data;
  logic              hold_vld;
  logic              new_byte;
  logic              consume;
  logic [ADDR_W-1:0] clr_addr, clr_addr_d;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W-1:0] wr_addr_d;
  logic [7:0]        wr_data_d;
  logic              wr_en_d;
  logic              busy_d;
  logic [6:0]        col_d;
  logic [4:0]        row_d;
  logic [4:0]        row_inc;
  logic              unused_done0;

  // Only the rising edge seen in the synchronizer history marks a new byte.
  assign new_byte     = (spi_done[2:1] == 2'b01);
  assign unused_done0 = spi_done[0];
  assign cur_addr     = ADDR_W'(cursor_row) * COLS_A + ADDR_W'(cursor_col);
  assign row_inc      = (cursor_row == ROW_MAX) ? 5'd0 : cursor_row + 5'd1;
  assign fsm_state    = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d    = state;
    col_d      = cursor_col;
    row_d      = cursor_row;
    clr_addr_d = clr_addr;
    wr_addr_d  = wr.wr_addr;
    wr_data_d  = wr.wr_data;
    wr_en_d    = 1'b0;
    busy_d     = 1'b0;
    consume    = 1'b0;
    case (state)
      IDLE: begin
        if (hold_vld) begin
          consume = 1'b1;
          case (hold_data)
            8'h0D: col_d = 7'd0;
            8'h0A: row_d = row_inc;
            8'h08: begin
              if (cursor_col != 7'd0) begin
                col_d     = cursor_col - 7'd1;
                wr_addr_d = cur_addr - ADDR_W'(1);
                wr_data_d = BLANK;
                wr_en_d   = 1'b1;
              end
            end
            8'h0C: begin
              state_d    = CLEAR;
              clr_addr_d = '0;
              wr_addr_d  = '0;
            end
`ifdef CURSOR_ESC_EN
            8'h1B: state_d = ESC_COL;
`endif
            default: begin
              wr_addr_d = cur_addr;
              wr_data_d = hold_data;
              wr_en_d   = 1'b1;
              if (cursor_col == COL_MAX) begin
                col_d = 7'd0;
                row_d = row_inc;
              end else begin
                col_d = cursor_col + 7'd1;
              end
            end
          endcase
        end
      end
      CLEAR: begin
        wr_en_d    = 1'b1;
        busy_d     = 1'b1;
        wr_addr_d  = clr_addr;
        wr_data_d  = BLANK;
        clr_addr_d = clr_addr + ADDR_W'(1);
        if (clr_addr == LAST_A) begin
          state_d = IDLE;
          col_d   = 7'd0;
          row_d   = 5'd0;
        end
      end
`ifdef CURSOR_ESC_EN
      ESC_COL: begin
        if (hold_vld) begin
          consume = 1'b1;
          col_d   = (hold_data > {1'b0, COL_MAX}) ? COL_MAX : hold_data[6:0];
          state_d = ESC_ROW;
        end
      end
      ESC_ROW: begin
        if (hold_vld) begin
          consume = 1'b1;
          row_d   = (hold_data > {3'b000, ROW_MAX}) ? ROW_MAX : hold_data[4:0];
          state_d = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_data  <= 8'd0;
      hold_vld   <= 1'b0;
      overflow   <= 1'b0;
      clr_addr   <= '0;
      wr.wr_addr <= '0;
      wr.wr_data <= 8'd0;
      wr.wr_en   <= 1'b0;
      cursor_col <= 7'd0;
      cursor_row <= 5'd0;
      busy       <= 1'b0;
    end else begin
      // A consume on this edge frees the entry for a byte arriving on the same edge.
      if (new_byte) begin
        if (hold_vld && !consume) begin
          overflow <= 1'b1;
        end else begin
          hold_data <= spi_shift_reg;
          hold_vld  <= 1'b1;
        end
      end else if (consume) begin
        hold_vld <= 1'b0;
      end
      clr_addr   <= clr_addr_d;
      wr.wr_addr <= wr_addr_d;
      wr.wr_data <= wr_data_d;
      wr.wr_en   <= wr_en_d;
      cursor_col <= col_d;
      cursor_row <= row_d;
      busy       <= busy_d;
    end
  end

endmodule

// File: tb/tb_text_write_ctrl.sv
// Bench for text_write_ctrl: a cursor/screen reference model feeds an expected-write queue checked by a monitor.
module tb_text_write_ctrl;
  localparam int COLS = 80;
  localparam int ROWS = 30;
  localparam int ADDR_W = 12;
`ifdef CURSOR_ESC_EN
  localparam bit ESC_EN = 1'b1;
`else
  localparam bit ESC_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] spi_shift_reg = 8'd0;
  logic [2:0] spi_done = 3'd0;
  logic [6:0] cursor_col;
  logic [4:0] cursor_row;
  logic       busy;
  logic       overflow;
  logic [1:0] fsm_state;

  text_write_ctrl_if #(.ADDR_W(ADDR_W)) wr_bus ();

  text_write_ctrl #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W), .BLANK(8'h20)) dut (
    .clk(clk), .rst_n(rst_n), .spi_shift_reg(spi_shift_reg), .spi_done(spi_done),
    .wr(wr_bus), .cursor_col(cursor_col), .cursor_row(cursor_row),
    .busy(busy), .overflow(overflow), .fsm_state(fsm_state)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [ADDR_W+7:0] exp_q[$];
  int last_wr_addr = -1;
  int busy_run = 0;
  int last_busy_len = 0;

  // Reference model state
  int m_col, m_row, m_esc;
  bit m_clearing, m_held, m_ovf;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_wr(input int addr, input logic [7:0] data);
    exp_q.push_back({ADDR_W'(addr), data});
  endtask

  task automatic model_reset();
    m_col = 0; m_row = 0; m_esc = 0;
    m_clearing = 0; m_held = 0; m_ovf = 0;
    exp_q.delete();
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (m_clearing) begin
      if (m_held) begin
        m_ovf = 1;
        return;
      end
      m_held = 1;
    end
    if (m_esc == 1) begin
      m_col = (int'(b) > COLS - 1) ? COLS - 1 : int'(b);
      m_esc = 2;
    end else if (m_esc == 2) begin
      m_row = (int'(b) > ROWS - 1) ? ROWS - 1 : int'(b);
      m_esc = 0;
    end else if (b == 8'h0D) begin
      m_col = 0;
    end else if (b == 8'h0A) begin
      m_row = (m_row + 1) % ROWS;
    end else if (b == 8'h08) begin
      if (m_col > 0) begin
        m_col--;
        push_wr(m_row * COLS + m_col, 8'h20);
      end
    end else if (b == 8'h0C) begin
      for (int i = 0; i < COLS * ROWS; i++) push_wr(i, 8'h20);
      m_col = 0; m_row = 0;
      m_clearing = 1; m_held = 0;
    end else if (ESC_EN && b == 8'h1B) begin
      m_esc = 1;
    end else begin
      push_wr(m_row * COLS + m_col, b);
      m_col++;
      if (m_col == COLS) begin
        m_col = 0;
        m_row = (m_row + 1) % ROWS;
      end
    end
  endtask

  // Scoreboard monitor: every write the DUT issues must be the next expected one.
  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_bus.wr_en) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_write: got addr %0d data %0h expected no write", wr_bus.wr_addr, wr_bus.wr_data);
        end else begin
          logic [ADDR_W+7:0] e;
          e = exp_q.pop_front();
          check("wr_addr", 32'(wr_bus.wr_addr), 32'(e[ADDR_W+7:8]));
          check("wr_data", 32'(wr_bus.wr_data), 32'(e[7:0]));
          last_wr_addr = int'(wr_bus.wr_addr);
        end
      end
      if (busy) begin
        check("busy_wr_en", 32'(wr_bus.wr_en), 32'd1);
        busy_run++;
      end else if (busy_run != 0) begin
        last_busy_len = busy_run;
        busy_run = 0;
      end
    end else begin
      busy_run = 0;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    spi_done = 3'd0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_wr_addr"}, 32'(wr_bus.wr_addr), 32'd0);
    check({tag, "_wr_data"}, 32'(wr_bus.wr_data), 32'd0);
    check({tag, "_wr_en"}, 32'(wr_bus.wr_en), 32'd0);
    check({tag, "_col"}, 32'(cursor_col), 32'd0);
    check({tag, "_row"}, 32'(cursor_row), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_overflow"}, 32'(overflow), 32'd0);
  endtask

  task automatic send_byte(input logic [7:0] b);
    model_byte(b);
    @(negedge clk);
    spi_shift_reg = b;
    spi_done = 3'b010;
    @(negedge clk);
    spi_done = 3'b000;
    repeat (3) @(negedge clk);
    if (!m_clearing) begin
      check("cursor_col", 32'(cursor_col), 32'(m_col));
      check("cursor_row", 32'(cursor_row), 32'(m_row));
    end
  endtask

  // Byte with latency check: write must not be visible after the detect edge, but must be after the next.
  task automatic send_timed(input logic [7:0] b);
    model_byte(b);
    @(negedge clk);
    spi_shift_reg = b;
    spi_done = 3'b010;
    @(posedge clk);
    #1;
    spi_done = 3'b000;
    check("lat_early_wr_en", 32'(wr_bus.wr_en), 32'd0);
    @(posedge clk);
    #1;
    check("lat_on_wr_en", 32'(wr_bus.wr_en), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_clear_done();
    int n;
    n = 0;
    while (!busy && n < 20) begin @(negedge clk); n++; end
    n = 0;
    while (busy && n < 3000) begin @(negedge clk); n++; end
    check("clear_timeout_busy", 32'(busy), 32'd0);
    m_clearing = 0;
    m_held = 0;
  endtask

  task automatic check_cursor(input string name, input int c, input int r);
    check({name, "_col"}, 32'(cursor_col), 32'(c));
    check({name, "_row"}, 32'(cursor_row), 32'(r));
  endtask

  initial begin
    logic [7:0] b;
    model_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    check("reset_fsm", 32'(fsm_state), 32'd0);
    rst_n = 1'b1;

    // Printable bytes with latency
    send_timed(8'h41);
    send_timed(8'h42);
    check_cursor("two_chars", 2, 0);

    // Row wrap and bottom-right wrap
    do_reset();
    for (int i = 0; i < COLS; i++) send_byte(8'h61 + 8'(i % 26));
    send_byte(8'h43);
    check("wrap_addr", 32'(last_wr_addr), 32'd80);
    check_cursor("row_wrap", 1, 1);
    for (int i = 0; i < 28; i++) send_byte(8'h0A);
    for (int i = 0; i < 78; i++) send_byte(8'h30 + 8'(i % 10));
    check_cursor("bottom_right", 79, 29);
    send_byte(8'h7A);
    check("last_cell_addr", 32'(last_wr_addr), 32'd2399);
    check_cursor("screen_wrap", 0, 0);

    // CR / LF / BS
    for (int i = 0; i < 3; i++) send_byte(8'h0A);
    for (int i = 0; i < 5; i++) send_byte(8'h4D);
    check_cursor("at_5_3", 5, 3);
    send_byte(8'h08);
    check("bs_addr", 32'(last_wr_addr), 32'd244);
    check_cursor("bs", 4, 3);
    send_byte(8'h0D);
    check_cursor("cr", 0, 3);
    send_byte(8'h0A);
    check_cursor("lf", 0, 4);
    send_byte(8'h08);
    check_cursor("bs_col0", 0, 4);

    // Clear screen with a byte arriving mid-clear
    send_byte(8'h0C);
    repeat (50) @(negedge clk);
    check("clear_busy", 32'(busy), 32'd1);
    send_byte(8'h58);
    wait_clear_done();
    repeat (4) @(negedge clk);
    check("clear_len", 32'(last_busy_len), 32'd2400);
    check_cursor("after_clear", 1, 0);
    check("after_clear_addr", 32'(last_wr_addr), 32'd0);

    // Cursor escape
    do_reset();
`ifdef CURSOR_ESC_EN
    send_byte(8'h1B); send_byte(8'h0A); send_byte(8'h05);
    check_cursor("esc", 10, 5);
    send_byte(8'h5A);
    check("esc_write_addr", 32'(last_wr_addr), 32'd410);
    send_byte(8'h1B); send_byte(8'd200); send_byte(8'd200);
    check_cursor("esc_clamp", 79, 29);
`else
    send_byte(8'h1B);
    check("esc_plain_addr", 32'(last_wr_addr), 32'd0);
    check_cursor("esc_plain", 1, 0);
`endif

    // Randomized stream
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 9))
        0: b = 8'h0D;
        1: b = 8'h0A;
        2: b = 8'h08;
        3: b = 8'h1B;
        4: b = 8'($urandom_range(0, 255));
        default: b = 8'($urandom_range(32, 126));
      endcase
      if (b == 8'h0C) b = 8'h41;
      send_byte(b);
    end

    // Overflow during clear, then reset mid-clear
    do_reset();
    send_byte(8'h0C);
    repeat (40) @(negedge clk);
    send_byte(8'h31);
    send_byte(8'h32);
    check("overflow_set", 32'(overflow), 32'(m_ovf));
    wait_clear_done();
    repeat (4) @(negedge clk);
    check("overflow_sticky", 32'(overflow), 32'd1);
    check_cursor("after_ovf_clear", 1, 0);
    send_byte(8'h0C);
    repeat (100) @(negedge clk);
    check("midclear_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs_zero("midclear_reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("post_reset_busy", 32'(busy), 32'd0);

    repeat (5) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
